// File: rtl/actuator_pkg.sv
// Shared definitions for the actuator matrix scanner: command encodings,
// scan FSM states and frame sizing.
package actuator_pkg;

  localparam logic [1:0] CMD_OFF = 2'b00;
  localparam logic [1:0] CMD_FWD = 2'b01;
  localparam logic [1:0] CMD_REV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Two command bits per actuator.
  function automatic int frame_bits(input int n_rows, input int n_cols);
    return 2 * n_rows * n_cols;
  endfunction

endpackage

// File: rtl/actuator_sync_edge.sv
// Pin-input synchroniser with registered one-cycle rise/fall pulses taken
// from the synchronised level and its one-cycle delay.
module actuator_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_reg;
  logic                   prev_reg;

  assign sync_out = chain_reg[SYNC_STAGES-1];

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= {SYNC_STAGES{RESET_VAL}};
      prev_reg  <= RESET_VAL;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in};
      prev_reg  <= sync_out;
      rise      <= sync_out & ~prev_reg;
      fall      <= ~sync_out & prev_reg;
    end
  end

endmodule

// File: rtl/actuator_matrix_scanner.sv
// ROWS x COLS actuator matrix scanner: SPI-loaded shadow frame, latched into an
// active frame, driven column by column in forward then reverse phases.
module actuator_matrix_scanner
  import actuator_pkg::*;
#(
  parameter int ROWS         = 5,
  parameter int COLS         = 2,
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 1000,
  parameter int DEAD_CYCLES  = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_n,
  input  logic              trigger_in_n,
  input  logic              latch_data_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic [ROWS-1:0]   rows,
  output logic [ROWS-1:0]   rows_enable,
  output logic [COLS-1:0]   cols,
  output logic [COLS-1:0]   cols_enable,
  output logic [2*ROWS-1:0] rows_hbridge,
  output logic [2*COLS-1:0] cols_hbridge,
  output logic              trigger_out_n,
  output logic              busy,
  output logic              frame_err
);

  localparam int FRAME_BITS = frame_bits(ROWS, COLS);
  localparam int BC_W       = $clog2(FRAME_BITS + 2);
  localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [BC_W-1:0]  BC_FULL    = BC_W'(FRAME_BITS);
  localparam logic [BC_W-1:0]  BC_SAT     = BC_W'(FRAME_BITS + 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES - 1);

  localparam int N_PIN = 6;
  localparam int P_EN = 0, P_TRIG = 1, P_LATCH = 2, P_SCLK = 3, P_SS = 4, P_MOSI = 5;
  // Idle levels, MSB first: mosi, ss_n, sclk, latch_data_n, trigger_in_n, enable_n.
  localparam logic [N_PIN-1:0] PIN_IDLE = 6'b010111;

  logic [N_PIN-1:0] pin_async, pin_sync, pin_rise, pin_fall;
  assign pin_async = {mosi, ss_n, sclk, latch_data_n, trigger_in_n, enable_n};

  for (genvar gi = 0; gi < N_PIN; gi++) begin : g_sync
    actuator_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (PIN_IDLE[gi])
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(pin_async[gi]),
      .sync_out(pin_sync[gi]),
      .rise    (pin_rise[gi]),
      .fall    (pin_fall[gi])
    );
  end

  logic unused_pins;
  assign unused_pins = ^{pin_sync[P_TRIG], pin_sync[P_LATCH], pin_sync[P_SCLK],
                         pin_rise[P_EN], pin_fall[P_EN], pin_rise[P_TRIG],
                         pin_rise[P_LATCH], pin_rise[P_MOSI], pin_fall[P_MOSI]};

  logic abort;
  assign abort = pin_sync[P_EN];

  logic [FRAME_BITS-1:0] shadow_reg, active_reg, shift_reg;
  logic [BC_W-1:0]       bit_cnt_reg;
  logic                  pending_reg;
  state_t                state_reg;
  logic [COL_W-1:0]      col_reg;
  logic                  ph_reg;
  logic [CNT_W-1:0]      timer_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      shadow_reg  <= '0;
      frame_err   <= 1'b0;
      miso        <= 1'b0;
    end else begin
      if (pin_fall[P_SS]) begin
        shift_reg   <= active_reg;
        bit_cnt_reg <= '0;
      end else if (pin_rise[P_SCLK] && !pin_sync[P_SS]) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], pin_sync[P_MOSI]};
        if (bit_cnt_reg != BC_SAT)
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (pin_fall[P_SCLK])
        miso <= shift_reg[FRAME_BITS-1];
      if (pin_rise[P_SS]) begin
        if (bit_cnt_reg == BC_FULL) begin
          shadow_reg <= shift_reg;
          frame_err  <= 1'b0;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  // A scan ends normally in DONE or early on enable_n; either way a held latch lands.
  logic scan_end;
  assign scan_end = (state_reg == ST_DONE) || (abort && state_reg != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg  <= '0;
      pending_reg <= 1'b0;
      state_reg   <= ST_IDLE;
      col_reg     <= '0;
      ph_reg      <= 1'b0;
      timer_reg   <= '0;
    end else begin
      if (scan_end) begin
        if (pending_reg || pin_fall[P_LATCH])
          active_reg <= shadow_reg;
        pending_reg <= 1'b0;
      end else if (pin_fall[P_LATCH]) begin
        if (state_reg == ST_IDLE) active_reg <= shadow_reg;
        else                      pending_reg <= 1'b1;
      end

      if (abort) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: if (pin_fall[P_TRIG]) begin
            state_reg <= ST_DRIVE;
            col_reg   <= '0;
            ph_reg    <= 1'b0;
            timer_reg <= PULSE_LOAD;
          end
          ST_DRIVE: if (timer_reg == '0) begin
            state_reg <= ST_DEAD;
            timer_reg <= DEAD_LOAD;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
          ST_DEAD: if (timer_reg == '0) begin
            if (!ph_reg) begin
              ph_reg    <= 1'b1;
              state_reg <= ST_DRIVE;
              timer_reg <= PULSE_LOAD;
            end else if (col_reg != COL_LAST) begin
              col_reg   <= col_reg + 1'b1;
              ph_reg    <= 1'b0;
              state_reg <= ST_DRIVE;
              timer_reg <= PULSE_LOAD;
            end else begin
              state_reg <= ST_DONE;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  logic                  driving;
  logic [2*ROWS-1:0]     col_cmds;
  logic [ROWS-1:0]       row_match;
  logic [ROWS-1:0]       rows_en_next, rows_next;
  logic [COLS-1:0]       cols_en_next, cols_next;
  logic [2*ROWS-1:0]     rows_hb_next;
  logic [2*COLS-1:0]     cols_hb_next;

  assign driving  = (state_reg == ST_DRIVE) && !abort;
  assign col_cmds = active_reg[int'(col_reg)*2*ROWS +: 2*ROWS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_match[gi]          = (col_cmds[2*gi +: 2] == (ph_reg ? CMD_REV : CMD_FWD));
    assign rows_en_next[gi]       = driving & row_match[gi];
    assign rows_next[gi]          = rows_en_next[gi] & ~ph_reg;
    assign rows_hb_next[2*gi+1]   = rows_en_next[gi] & rows_next[gi];
    assign rows_hb_next[2*gi]     = rows_en_next[gi] & ~rows_next[gi];
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign cols_en_next[gi]       = driving && (int'(col_reg) == gi);
    assign cols_next[gi]          = cols_en_next[gi] & ph_reg;
    assign cols_hb_next[2*gi+1]   = cols_en_next[gi] & cols_next[gi];
    assign cols_hb_next[2*gi]     = cols_en_next[gi] & ~cols_next[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows          <= '0;
      rows_enable   <= '0;
      cols          <= '0;
      cols_enable   <= '0;
      rows_hbridge  <= '0;
      cols_hbridge  <= '0;
      trigger_out_n <= 1'b1;
      busy          <= 1'b0;
    end else begin
      rows          <= rows_next;
      rows_enable   <= rows_en_next;
      cols          <= cols_next;
      cols_enable   <= cols_en_next;
      rows_hbridge  <= rows_hb_next;
      cols_hbridge  <= cols_hb_next;
      trigger_out_n <= !((state_reg == ST_DONE) && !abort);
      busy          <= (state_reg != ST_IDLE) && !abort;
    end
  end

endmodule

// File: tb/tb_actuator_matrix_scanner.sv
// Directed bench for actuator_matrix_scanner at ROWS=5, COLS=2, PULSE=8, DEAD=2.
module tb_actuator_matrix_scanner;

  logic clk = 1'b0;
  logic rst, enable_n, trigger_in_n, latch_data_n, sclk, mosi, ss_n;
  logic miso, trigger_out_n, busy, frame_err;
  logic [4:0] rows, rows_enable;
  logic [1:0] cols, cols_enable;
  logic [9:0] rows_hbridge;
  logic [3:0] cols_hbridge;
  logic [27:0] drv;

  int checks = 0;
  int errors = 0;

  assign drv = {rows_enable, rows, cols_enable, cols, rows_hbridge, cols_hbridge};

  always #5 clk = ~clk;

  actuator_matrix_scanner #(
    .ROWS(5), .COLS(2), .CNT_W(16), .PULSE_CYCLES(8), .DEAD_CYCLES(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable_n(enable_n), .trigger_in_n(trigger_in_n),
    .latch_data_n(latch_data_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
    .rows(rows), .rows_enable(rows_enable), .cols(cols), .cols_enable(cols_enable),
    .rows_hbridge(rows_hbridge), .cols_hbridge(cols_hbridge),
    .trigger_out_n(trigger_out_n), .busy(busy), .frame_err(frame_err)
  );

  // Per-phase drive vectors {rows_enable, rows, cols_enable, cols, rows_hbridge, cols_hbridge}.
  // Frame 0x00009: r0c0 forward, r1c0 reverse.
  localparam logic [3:0][27:0] EXP_FWD = {
    {5'b00000, 5'b00000, 2'b10, 2'b10, 10'b0000000000, 4'b1000},
    {5'b00000, 5'b00000, 2'b10, 2'b00, 10'b0000000000, 4'b0100},
    {5'b00010, 5'b00000, 2'b01, 2'b01, 10'b0000000100, 4'b0010},
    {5'b00001, 5'b00001, 2'b01, 2'b00, 10'b0000000010, 4'b0001}};
  // Frame 0x08000: r2c1 reverse only.
  localparam logic [3:0][27:0] EXP_REV = {
    {5'b00100, 5'b00000, 2'b10, 2'b10, 10'b0000010000, 4'b1000},
    {5'b00000, 5'b00000, 2'b10, 2'b00, 10'b0000000000, 4'b0100},
    {5'b00000, 5'b00000, 2'b01, 2'b01, 10'b0000000000, 4'b0010},
    {5'b00000, 5'b00000, 2'b01, 2'b00, 10'b0000000000, 4'b0001}};

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_write(input logic [19:0] frame, input int nbits);
    ss_n = 1'b0;
    wait_cyc(6);
    for (int k = nbits - 1; k >= 0; k--) begin
      mosi = frame[k];
      sclk = 1'b1;
      wait_cyc(5);
      sclk = 1'b0;
      wait_cyc(5);
    end
    mosi = 1'b0;
    ss_n = 1'b1;
    wait_cyc(6);
  endtask

  task automatic pulse_latch();
    latch_data_n = 1'b0;
    wait_cyc(5);
    latch_data_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_reset();
    checks++;
    if (drv !== 28'h0 || busy !== 1'b0 || trigger_out_n !== 1'b1 ||
        miso !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: drv=%h busy=%b trig_n=%b miso=%b ferr=%b, want 0 0 1 0 0",
               drv, busy, trigger_out_n, miso, frame_err);
    end
    $display("reset: drv=%h busy=%b trig_n=%b", drv, busy, trigger_out_n);
  endtask

  task automatic test_readback(input string name, input logic [19:0] exp_frame);
    logic eb;
    ss_n = 1'b0;
    wait_cyc(6);
    for (int k = 1; k <= 20; k++) begin
      sclk = 1'b1;
      wait_cyc(5);
      sclk = 1'b0;
      wait_cyc(5);
      eb = (k < 20) ? exp_frame[19-k] : 1'b0;
      checks++;
      if (miso !== eb) begin
        errors++;
        $display("FAIL %s bit%0d: miso=%b want %b", name, k, miso, eb);
      end
    end
    ss_n = 1'b1;
    wait_cyc(6);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_err: got %b want 0", name, frame_err);
    end
    $display("%s: readback of %h done", name, exp_frame);
  endtask

  task automatic scan_and_check(input string name, input logic [3:0][27:0] exp, input bit disturb);
    int lat;
    int pulses;
    logic [27:0] e;
    logic eb, et;
    trigger_in_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (drv == 28'h0 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles want 4", name, lat);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 40) begin
        e  = ((i % 10) < 8) ? exp[i/10] : 28'h0;
        eb = 1'b1;
        et = 1'b1;
      end else if (i == 40) begin
        e = 28'h0; eb = 1'b1; et = 1'b0;
      end else begin
        e = 28'h0; eb = 1'b0; et = 1'b1;
      end
      checks++;
      if (drv !== e || busy !== eb || trigger_out_n !== et) begin
        errors++;
        $display("FAIL %s cycle%0d: drv=%h busy=%b trig_n=%b want drv=%h busy=%b trig_n=%b",
                 name, i, drv, busy, trigger_out_n, e, eb, et);
      end
      if (trigger_out_n === 1'b0) pulses++;
      if (i == 1) trigger_in_n = 1'b1;
      if (disturb && i == 5) begin
        latch_data_n = 1'b0;
        trigger_in_n = 1'b0;
      end
      if (disturb && i == 15) begin
        latch_data_n = 1'b1;
        trigger_in_n = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL %s trigger_out_pulses: got %0d want 1", name, pulses);
    end
    $display("%s: latency=%0d trigger_out pulses=%0d", name, lat, pulses);
  endtask

  task automatic test_scan_fwd();
    spi_write(20'h00009, 20);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL fwd_frame_err: got %b want 0", frame_err);
    end
    pulse_latch();
    scan_and_check("scan_fwd", EXP_FWD, 1'b0);
  endtask

  task automatic test_scan_rev();
    spi_write(20'h08000, 20);
    pulse_latch();
    scan_and_check("scan_rev", EXP_REV, 1'b0);
  endtask

  task automatic test_frame_err();
    spi_write(20'h00009, 19);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_frame_err: got %b want 1", frame_err);
    end
    pulse_latch();
    test_readback("readback_after_short", 20'h08000);
  endtask

  task automatic test_latch_during_scan();
    spi_write(20'h00009, 20);
    scan_and_check("scan_latch_busy", EXP_REV, 1'b1);
    test_readback("readback_after_done", 20'h00009);
  endtask

  task automatic test_enable_abort();
    int lat;
    int bad;
    trigger_in_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (drv == 28'h0 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    wait_cyc(2);
    enable_n = 1'b1;
    wait_cyc(2);
    checks++;
    if (drv !== EXP_FWD[0] || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_before_sync: drv=%h busy=%b want drv=%h busy=1", drv, busy, EXP_FWD[0]);
    end
    wait_cyc(1);
    checks++;
    if (drv !== 28'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: drv=%h busy=%b want 0 0", drv, busy);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (trigger_out_n !== 1'b1 || busy !== 1'b0) bad++;
      if (i == 3) trigger_in_n = 1'b1;
      wait_cyc(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_no_pulse: %0d cycles with trig_n low or busy, want 0", bad);
    end
    enable_n = 1'b0;
    wait_cyc(6);
    $display("enable_abort: outputs cleared, bad cycles=%0d", bad);
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    spi_write(20'h00009, 19);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_frame_err: got %b want 1", frame_err);
    end
    trigger_in_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (drv == 28'h0 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    wait_cyc(3);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (drv !== 28'h0 || busy !== 1'b0 || trigger_out_n !== 1'b1 ||
        miso !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: drv=%h busy=%b trig_n=%b miso=%b ferr=%b, want 0 0 1 0 0",
               drv, busy, trigger_out_n, miso, frame_err);
    end
    trigger_in_n = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(6);
    $display("reset_mid_scan: outputs cleared without a clock edge");
    test_readback("readback_after_reset", 20'h00000);
  endtask

  initial begin
    rst = 1'b1;
    enable_n = 1'b0;
    trigger_in_n = 1'b1;
    latch_data_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    ss_n = 1'b1;
    wait_cyc(4);
    test_reset();
    rst = 1'b0;
    wait_cyc(6);
    test_scan_fwd();
    test_readback("readback_fwd", 20'h00009);
    test_scan_rev();
    test_frame_err();
    test_latch_during_scan();
    test_enable_abort();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
